// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU command controller.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_GT   = 4'b0011;
    localparam logic [3:0] OP_LT   = 4'b0100;
    localparam logic [3:0] OP_EQ   = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_SHL  = 4'b1001;
    localparam logic [3:0] OP_SHR  = 4'b1010;
    localparam logic [3:0] OP_LAST = OP_SHR;

    localparam int FLG_CERO  = 0;
    localparam int FLG_NEG   = 1;
    localparam int FLG_OVF   = 2;
    localparam int FLG_CARRY = 3;
    localparam int FLG_ERR   = 4;
    localparam int FLG_W     = 5;

    // Shift distances beyond one operand width leave no meaningful carry bit.
    localparam int SHIFT_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } ctrl_state_t;

    function automatic logic [FLG_W-1:0] pack_flags(
        input logic err,
        input logic carry,
        input logic ovf,
        input logic neg,
        input logic cero
    );
        logic [FLG_W-1:0] f;
        f            = '0;
        f[FLG_ERR]   = err;
        f[FLG_CARRY] = carry;
        f[FLG_OVF]   = ovf;
        f[FLG_NEG]   = neg;
        f[FLG_CERO]  = cero;
        return f;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible on dout while not empty.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_controller.sv
// Command front-end and result back-end around an external 8-bit combinational ALU.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no command in flight; pops the FIFO head as soon as one exists
// ST_ISSUE | operands registered on alu_*, ALU settling; capture on next edge
// ST_HOLD  | result presented on res_*; waits for res_ready
module alu_cmd_controller
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8,
    parameter int RES_W      = 16,
    parameter int SEL_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SEL_W-1:0]  cmd_sel,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [SEL_W-1:0]  alu_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [RES_W-1:0]  alu_c,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic              alu_negativo,
    input  logic              alu_cero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [FLG_W-1:0]  res_flags,
    output logic [15:0]       ops_done,
    output logic              busy
);

    localparam int ENT_W = SEL_W + 2 * DATA_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ctrl_state_t       state;
    ctrl_state_t       state_nxt;

    logic [ENT_W-1:0]  fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              capture;
    logic              res_fire;

    logic              cap_err;
    logic              shift_big;
    logic [RES_W-1:0]  cap_data;
    logic [FLG_W-1:0]  cap_flags;

    assign cmd_ready = !rst && !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign res_fire  = res_valid && res_ready;
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({cmd_sel, cmd_a, cmd_b}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready) begin
                    state_nxt = fifo_empty ? ST_IDLE : ST_ISSUE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // A completed handshake and the next pop share one edge, giving one result per two cycles.
    always_comb begin
        pop     = 1'b0;
        capture = 1'b0;
        case (state)
            ST_IDLE:  pop     = !fifo_empty;
            ST_ISSUE: capture = 1'b1;
            ST_HOLD:  pop     = res_ready && !fifo_empty;
            default: begin
                pop     = 1'b0;
                capture = 1'b0;
            end
        endcase
    end

    always_comb begin
        cap_err   = (alu_sel > SEL_W'(OP_LAST));
        shift_big = ((alu_sel == SEL_W'(OP_SHL)) || (alu_sel == SEL_W'(OP_SHR)))
                    && (alu_b > DATA_W'(SHIFT_MAX));
        cap_data  = alu_c;
        cap_flags = pack_flags(1'b0, alu_carry && !shift_big, alu_overflow,
                               alu_negativo, alu_cero);
        if (cap_err) begin
            cap_data  = '0;
            cap_flags = pack_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_sel   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_flags <= '0;
            ops_done  <= '0;
        end else begin
            if (pop) begin
                {alu_sel, alu_a, alu_b} <= fifo_dout;
            end
            if (capture) begin
                res_data  <= cap_data;
                res_flags <= cap_flags;
                res_valid <= 1'b1;
            end else if (res_fire) begin
                res_valid <= 1'b0;
            end
            if (res_fire) begin
                ops_done <= ops_done + 16'd1;
            end
        end
    end

endmodule
